// File: rtl/athos_pkg.sv
// Shared types and default sizing for the athos result queue.
// Entry fields are sized to the largest supported id/data width; the queue uses the low bits.
package athos_pkg;

    localparam int ATHOS_DEPTH        = 4;
    localparam int ATHOS_ID_WIDTH     = 4;
    localparam int ATHOS_XLEN         = 32;
    localparam int ATHOS_ID_WIDTH_MAX = 8;
    localparam int ATHOS_XLEN_MAX     = 64;

    typedef enum logic [1:0] {
        ENT_FREE  = 2'd0,
        ENT_BUSY  = 2'd1,
        ENT_READY = 2'd2
    } ent_state_e;

    typedef struct packed {
        logic [ATHOS_ID_WIDTH_MAX-1:0] id;
        logic [4:0]                    rd;
        logic                          we;
        logic [ATHOS_XLEN_MAX-1:0]     data;
        logic                          committed;
        logic                          killed;
    } ent_t;

endpackage

// File: rtl/athos_rq_ptr.sv
// Head/tail pointers and occupancy count for the result queue circular buffer.
// Pointers wrap naturally because DEPTH is a power of two.
module athos_rq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH)-1:0] head_o,
    output logic [$clog2(DEPTH)-1:0] tail_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = pop_i  ? head_q + PW'(1) : head_q;
        tail_d  = push_i ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/athos_result_queue.sv
// In-order result queue between the athos execution core and the XIF result port.
// Optional ATHOS_RESULT_QUEUE_BYPASS_EN: same-cycle result for a lone, already committed head.
module athos_result_queue
    import athos_pkg::*;
#(
    parameter int DEPTH    = ATHOS_DEPTH,
    parameter int ID_WIDTH = ATHOS_ID_WIDTH,
    parameter int XLEN     = ATHOS_XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_valid_i,
    input  logic [ID_WIDTH-1:0] alloc_id_i,
    output logic                alloc_ready_o,
    input  logic                wb_valid_i,
    input  logic [ID_WIDTH-1:0] wb_id_i,
    input  logic [4:0]          wb_rd_i,
    input  logic                wb_we_i,
    input  logic [XLEN-1:0]     wb_data_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic                wb_err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ent_state_e st_q [DEPTH];
    ent_state_e st_d [DEPTH];
    ent_t       ent_q [DEPTH];
    ent_t       ent_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [DEPTH-1:0] wb_match, cm_match;

    logic [PW-1:0]       head, tail, nh;
    logic [CW-1:0]       count;
    logic                full, wb_hit, kill_free, bypass, retire, pop, alloc;
    logic                result_valid_q, result_valid_d;
    logic [ID_WIDTH-1:0] result_id_q, result_id_d;
    logic [4:0]          result_rd_q, result_rd_d;
    logic                result_we_q, result_we_d;
    logic [XLEN-1:0]     result_data_q, result_data_d;
    logic                wb_err_q, wb_err_d;

    athos_rq_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (alloc),
        .pop_i   (pop),
        .head_o  (head),
        .tail_o  (tail),
        .count_o (count)
    );

    always_comb begin
        wb_match = '0;
        cm_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] != ENT_FREE) begin
                wb_match[i] = (ent_q[i].id[ID_WIDTH-1:0] == wb_id_i);
                cm_match[i] = (ent_q[i].id[ID_WIDTH-1:0] == commit_id_i);
            end
        end
    end

    assign wb_hit    = |wb_match;
    // A killed head never presents a result; it just leaves the queue.
    assign kill_free = !rst_i && !result_valid_q && (st_q[head] == ENT_BUSY) && ent_q[head].killed;

`ifdef ATHOS_RESULT_QUEUE_BYPASS_EN
    assign bypass = !rst_i && !result_valid_q && (count == CW'(1)) && (st_q[head] == ENT_BUSY) &&
                    ent_q[head].committed && !ent_q[head].killed && wb_valid_i && wb_match[head];
`else
    assign bypass = 1'b0;
`endif

    assign result_valid_o = result_valid_q | bypass;
    assign result_id_o    = bypass ? wb_id_i   : result_id_q;
    assign result_rd_o    = bypass ? wb_rd_i   : result_rd_q;
    assign result_we_o    = bypass ? wb_we_i   : result_we_q;
    assign result_data_o  = bypass ? wb_data_i : result_data_q;
    assign wb_err_o       = wb_err_q;

    assign retire        = result_valid_o && result_ready_i && !rst_i;
    assign pop           = retire || kill_free;
    assign full          = (count == CW'(DEPTH));
    assign alloc_ready_o = rst_i || !full || pop;
    assign alloc         = alloc_valid_i && alloc_ready_o && !rst_i;
    assign nh            = pop ? head + PW'(1) : head;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i]      = st_q[i];
            ent_d[i]     = ent_q[i];
            written_d[i] = written_q[i];
            if (wb_valid_i && wb_match[i]) begin
                ent_d[i].rd   = wb_rd_i;
                ent_d[i].we   = wb_we_i;
                ent_d[i].data = ATHOS_XLEN_MAX'(wb_data_i);
                written_d[i]  = 1'b1;
            end
            if (commit_valid_i && cm_match[i]) begin
                if (commit_kill_i) ent_d[i].killed    = 1'b1;
                else               ent_d[i].committed = 1'b1;
            end
            if (st_d[i] == ENT_BUSY && written_d[i] && ent_d[i].committed && !ent_d[i].killed)
                st_d[i] = ENT_READY;
            if (pop && PW'(i) == head)
                st_d[i] = ENT_FREE;
            // Allocation after free so a full queue can retire and refill one slot per cycle.
            if (alloc && PW'(i) == tail) begin
                st_d[i]      = ENT_BUSY;
                ent_d[i]     = '0;
                ent_d[i].id  = ATHOS_ID_WIDTH_MAX'(alloc_id_i);
                written_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        wb_err_d       = wb_valid_i && !wb_hit;
        result_valid_d = result_valid_q;
        result_id_d    = result_id_q;
        result_rd_d    = result_rd_q;
        result_we_d    = result_we_q;
        result_data_d  = result_data_q;
        if (!(result_valid_q && !result_ready_i)) begin
            result_valid_d = (st_d[nh] == ENT_READY);
            result_id_d    = '0;
            result_rd_d    = '0;
            result_we_d    = 1'b0;
            result_data_d  = '0;
            if (st_d[nh] == ENT_READY) begin
                result_id_d   = ent_d[nh].id[ID_WIDTH-1:0];
                result_rd_d   = ent_d[nh].rd;
                result_we_d   = ent_d[nh].we;
                result_data_d = ent_d[nh].data[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]  <= ENT_FREE;
                ent_q[i] <= '0;
            end
            written_q      <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
            result_data_q  <= '0;
            wb_err_q       <= 1'b0;
        end else begin
            st_q           <= st_d;
            ent_q          <= ent_d;
            written_q      <= written_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_rd_q    <= result_rd_d;
            result_we_q    <= result_we_d;
            result_data_q  <= result_data_d;
            wb_err_q       <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_athos_result_queue.sv
// Scoreboard bench for athos_result_queue: expected results are queued in allocation order
// (killed ops omitted) and a negedge monitor pops them on each completed result handshake.
module tb_athos_result_queue;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int XLEN  = 32;
`ifdef ATHOS_RESULT_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            alloc_valid_i = 1'b0;
    logic [IDW-1:0]  alloc_id_i = '0;
    logic            alloc_ready_o;
    logic            wb_valid_i = 1'b0;
    logic [IDW-1:0]  wb_id_i = '0;
    logic [4:0]      wb_rd_i = '0;
    logic            wb_we_i = 1'b0;
    logic [XLEN-1:0] wb_data_i = '0;
    logic            commit_valid_i = 1'b0;
    logic [IDW-1:0]  commit_id_i = '0;
    logic            commit_kill_i = 1'b0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [IDW-1:0]  result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic [XLEN-1:0] result_data_o;
    logic            wb_err_o;

    athos_result_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .alloc_valid_i(alloc_valid_i), .alloc_id_i(alloc_id_i), .alloc_ready_o(alloc_ready_o),
        .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i),
        .wb_data_i(wb_data_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o),
        .result_data_o(result_data_o), .wb_err_o(wb_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] data;
    } res_t;

    typedef struct {
        logic [IDW-1:0]  id;
        logic [4:0]      rd;
        logic            we;
        logic [XLEN-1:0] data;
        bit              kill;
        bit              wbd;
        bit              cmd;
    } op_t;

    res_t exp_q[$];
    op_t  pend[$];
    int   total = 0;
    int   bad = 0;
    int   nid = 0;
    res_t got, prev_res;
    bit   prev_hold = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic [4:0] rd, input logic we,
                            input logic [XLEN-1:0] data);
        res_t r;
        r.id = id; r.rd = rd; r.we = we; r.data = data;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid_i  = 1'b0;
        wb_valid_i     = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic set_alloc(input logic [IDW-1:0] id);
        alloc_valid_i = 1'b1;
        alloc_id_i    = id;
    endtask

    task automatic set_wb(input logic [IDW-1:0] id, input logic [4:0] rd, input logic [XLEN-1:0] d);
        wb_valid_i = 1'b1; wb_id_i = id; wb_rd_i = rd; wb_we_i = 1'b1; wb_data_i = d;
    endtask

    task automatic set_cm(input logic [IDW-1:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge clk) begin
        got = {result_id_o, result_rd_o, result_we_o, result_data_o};
        if (!rst_i) begin
            if (prev_hold)
                chk("hold_stable", 64'({result_valid_o, got}), 64'({1'b1, prev_res}));
            if (result_valid_o && result_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got id %0h, expected no result", result_id_o);
                end else begin
                    chk("result", 64'(got), 64'(exp_q.pop_front()));
                end
            end
        end
        prev_hold = !rst_i && result_valid_o && !result_ready_i;
        prev_res  = got;
    end

    task automatic run_cycle(input bit allow_alloc);
        int  wi, ci, k;
        bit  acc;
        op_t nop;
        wi = -1; ci = -1;
        result_ready_i = ($urandom_range(0, 3) != 0);
        if (pend.size() > 0) begin
            k = $urandom_range(0, pend.size() - 1);
            if (!pend[k].wbd && $urandom_range(0, 1) == 1) begin
                wi = k;
                wb_valid_i = 1'b1; wb_id_i = pend[k].id; wb_rd_i = pend[k].rd;
                wb_we_i = pend[k].we; wb_data_i = pend[k].data;
            end
            k = $urandom_range(0, pend.size() - 1);
            // Kills go out only after the writeback so no late writeback hits a freed entry.
            if (!pend[k].cmd && (!pend[k].kill || pend[k].wbd) && $urandom_range(0, 1) == 1) begin
                ci = k;
                set_cm(pend[k].id, pend[k].kill);
            end
        end
        nop.id = IDW'(nid); nop.rd = 5'($urandom_range(0, 31)); nop.we = 1'($urandom_range(0, 1));
        nop.data = $urandom; nop.kill = ($urandom_range(0, 4) == 0); nop.wbd = 1'b0; nop.cmd = 1'b0;
        if (allow_alloc && $urandom_range(0, 1) == 1) set_alloc(nop.id);
        #1;
        acc = alloc_valid_i && alloc_ready_o;
        tick();
        if (wi >= 0) pend[wi].wbd = 1'b1;
        if (ci >= 0) pend[ci].cmd = 1'b1;
        if (acc) begin
            pend.push_back(nop);
            if (!nop.kill) push_exp(nop.id, nop.rd, nop.we, nop.data);
            nid++;
        end
        for (int j = pend.size() - 1; j >= 0; j--)
            if (pend[j].wbd && pend[j].cmd) pend.delete(j);
        chk("wb_err_quiet", 64'(wb_err_o), 64'(0));
    endtask

    initial begin
        int guard;
        // Reset state while rst_i is held
        tick(); tick();
        chk("rst_valid", 64'(result_valid_o), 64'(0));
        chk("rst_alloc_ready", 64'(alloc_ready_o), 64'(1));
        chk("rst_wb_err", 64'(wb_err_o), 64'(0));
        chk("rst_fields", 64'({result_id_o, result_rd_o, result_we_o, result_data_o}), 64'(0));
        rst_i = 1'b0;
        tick();

        // Single op
        result_ready_i = 1'b1;
        set_alloc(4'd3); push_exp(4'd3, 5'd5, 1'b1, 32'hDEADBEEF); tick();
        set_wb(4'd3, 5'd5, 32'hDEADBEEF); tick();
        chk("single_wb_err", 64'(wb_err_o), 64'(0));
        set_cm(4'd3, 1'b0); #1;
        chk("single_pre_valid", 64'(result_valid_o), 64'(0));
        tick();
        chk("single_valid", 64'(result_valid_o), 64'(1));
        chk("single_fields", 64'({result_id_o, result_rd_o, result_we_o, result_data_o}),
            64'({4'd3, 5'd5, 1'b1, 32'hDEADBEEF}));
        tick();
        chk("single_retired", 64'(result_valid_o), 64'(0));

        // Out-of-order writebacks, in-order results
        for (int i = 1; i <= 3; i++) begin
            set_alloc(IDW'(i)); push_exp(IDW'(i), 5'(i), 1'b1, 32'h1000 + i); tick();
        end
        set_wb(4'd3, 5'd3, 32'h1003); tick();
        set_wb(4'd1, 5'd1, 32'h1001); tick();
        set_wb(4'd2, 5'd2, 32'h1002); tick();
        set_cm(4'd1, 1'b0); tick();
        set_cm(4'd2, 1'b0); tick();
        set_cm(4'd3, 1'b0); tick();
        tick(); tick();
        chk("ooo_drained", 64'(exp_q.size()), 64'(0));

        // Kill
        set_alloc(4'd4); tick();
        set_alloc(4'd5); push_exp(4'd5, 5'd9, 1'b1, 32'h5555); tick();
        set_cm(4'd4, 1'b1); tick();
        set_cm(4'd5, 1'b0); tick();
        set_wb(4'd5, 5'd9, 32'h5555); tick();
        chk("kill_wb5_err", 64'(wb_err_o), 64'(0));
        tick(); tick();
        chk("kill_drained", 64'(exp_q.size()), 64'(0));
        set_wb(4'd4, 5'd1, 32'h4444); tick();
        chk("kill_late_wb_err", 64'(wb_err_o), 64'(1));
        tick();
        chk("kill_err_pulse_end", 64'(wb_err_o), 64'(0));

        // Full queue and backpressure
        result_ready_i = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            set_alloc(IDW'(i)); push_exp(IDW'(i), 5'(i), 1'b1, 32'hA000 + i); tick();
        end
        chk("full_alloc_ready", 64'(alloc_ready_o), 64'(0));
        set_wb(4'd6, 5'd6, 32'hA006); tick();
        set_cm(4'd6, 1'b0); tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_stable", 64'({result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o}),
                64'({1'b1, 4'd6, 5'd6, 1'b1, 32'hA006}));
            tick();
        end
        result_ready_i = 1'b1;
        set_alloc(4'd10); push_exp(4'd10, 5'd10, 1'b1, 32'hA00A); #1;
        chk("retire_alloc_ready", 64'(alloc_ready_o), 64'(1));
        tick();
        chk("refull_alloc_ready", 64'(alloc_ready_o), 64'(0));
        set_wb(4'd7, 5'd7, 32'hA007); set_cm(4'd7, 1'b0); tick();
        tick();
        result_ready_i = 1'b0;
        set_wb(4'd8, 5'd8, 32'hA008); set_cm(4'd8, 1'b0); tick();
        chk("pre_reset_valid", 64'(result_valid_o), 64'(1));

        // Reset during an active handshake, three entries live
        result_ready_i = 1'b1;
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        chk("mid_rst_outputs", 64'({result_valid_o, wb_err_o, result_id_o, result_rd_o, result_we_o,
                                    result_data_o}), 64'(0));
        chk("mid_rst_alloc_ready", 64'(alloc_ready_o), 64'(1));
        for (int c = 0; c < 8; c++) tick();
        chk("post_rst_quiet", 64'(result_valid_o), 64'(0));

        // Commit first, then writeback: bypass timing
        set_alloc(4'd2); push_exp(4'd2, 5'd7, 1'b1, 32'hCAFE0002); tick();
        set_cm(4'd2, 1'b0); tick();
        set_wb(4'd2, 5'd7, 32'hCAFE0002); #1;
        chk("bypass_wb_cycle", 64'(result_valid_o), 64'(BYP));
        tick();
        chk("bypass_next_cycle", 64'(result_valid_o), 64'(!BYP));
        tick(); tick();
        chk("bypass_drained", 64'(exp_q.size()), 64'(0));

        // Randomized traffic, then drain
        for (int c = 0; c < 400; c++) run_cycle(1'b1);
        guard = 0;
        while (pend.size() != 0 && guard < 400) begin
            run_cycle(1'b0);
            guard++;
        end
        chk("random_pending_issued", 64'(pend.size()), 64'(0));
        result_ready_i = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("random_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/athos_result_queue.md
ATHOS_RESULT_QUEUE -- requirements
Module: athos_result_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight result entries (power of two, at least 2).
REQ-002 Parameter ID_WIDTH, default 4, XIF instruction-id width.
REQ-003 Parameter XLEN, default 32, result data width.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 alloc_valid_i  in  1  an offloaded instruction was accepted on the issue interface.
REQ-007 alloc_id_i  in  ID_WIDTH  id of that instruction.
REQ-008 alloc_ready_o  out  1  a free entry exists.
REQ-009 wb_valid_i  in  1  the athos core produced a result.
REQ-010 wb_id_i, wb_rd_i, wb_we_i, wb_data_i  in  ID_WIDTH/5/1/XLEN  result fields.
REQ-011 commit_valid_i, commit_id_i, commit_kill_i  in  1/ID_WIDTH/1  commit interface.
REQ-012 result_valid_o, result_ready_i  out/in  1/1  XIF result handshake.
REQ-013 result_id_o, result_rd_o, result_we_o, result_data_o  out  ID_WIDTH/5/1/XLEN  XIF result fields.
REQ-014 wb_err_o  out  1  one-cycle pulse when a writeback matches no live entry.

Function
REQ-015 Entries are allocated in issue order in a circular buffer; head and tail pointers wrap modulo DEPTH.
REQ-016 An allocation occurs when alloc_valid_i and alloc_ready_o are both high; alloc_ready_o is low when all DEPTH entries are occupied.
REQ-017 Each entry has three states: FREE, then BUSY (allocated, data and/or commit still outstanding), then READY (data written and commit received with kill low).
REQ-018 A writeback writes the data into the non-FREE entry whose id equals wb_id_i; if no entry matches, the data is dropped and wb_err_o pulses.
REQ-019 A commit with kill low sets the committed flag of the matching entry; a commit with kill high sets its killed flag.
REQ-020 The head entry drives the result outputs when READY; result_valid_o is registered, so the result appears no earlier than one cycle after the last of writeback and commit.
REQ-021 Once asserted, result_valid_o and all result fields stay stable until result_ready_i is high; the head then frees and the pointer advances.
REQ-022 A killed head entry frees in one cycle without asserting result_valid_o; a later writeback to that id raises wb_err_o.
REQ-023 Allocation, writeback, commit and retire may occur in the same cycle; a retire on a full queue allows a same-cycle allocation.
REQ-024 Results always leave in allocation order, even when writebacks arrive out of order.

Reset
REQ-025 While rst_i is high: all entries go to FREE, pointers clear to 0, alloc_ready_o is high, and result_valid_o, wb_err_o and all result fields are 0.
REQ-026 A reset during an active result handshake discards the pending result; no handshake completes in that cycle.

Configuration
REQ-027 ATHOS_RESULT_QUEUE_BYPASS_EN defined: when the queue holds only the head entry, that entry is already committed and a writeback for it arrives, result_valid_o and the result fields are driven combinationally in the same cycle.
REQ-028 ATHOS_RESULT_QUEUE_BYPASS_EN undefined: there is no bypass path; the minimum writeback-to-result latency is 1 cycle.

Structure
REQ-029 The package athos_pkg holds the entry-state enum (FREE/BUSY/READY), the entry struct (id, rd, we, data, committed, killed) and the default parameter constants.
REQ-030 The pointer arithmetic and occupancy count are placed in one sub-module, athos_rq_ptr.
REQ-031 athos_result_queue sits between athos_top's execution core and the XIF result port inside athos_wrapper.

Verification
REQ-032 Single op: allocate id 3, write back 0xDEADBEEF to rd 5, commit with kill=0 -> result 1 cycle later: id 3, rd 5, we 1, data 0xDEADBEEF.
REQ-033 Out-of-order writeback: allocate ids 1, 2, 3; write back 3, 1, 2; commit all -> results emitted in order 1, 2, 3.
REQ-034 Kill: allocate ids 4 and 5, kill 4, commit 5 and write it back -> only id 5 is emitted; a later writeback to id 4 pulses wb_err_o.
REQ-035 Full/backpressure: allocate 4 entries -> alloc_ready_o goes to 0; hold result_ready_i at 0 for 5 cycles -> outputs stay stable; one retire plus a same-cycle allocation is accepted.
REQ-036 Reset mid-operation: 3 entries live with result_valid_o high, assert rst_i for 1 cycle -> all outputs 0, alloc_ready_o 1, no result emitted afterwards.
REQ-037 Bypass: with ATHOS_RESULT_QUEUE_BYPASS_EN defined, commit id 2 first, then write it back -> result_valid_o is high in the writeback cycle; without the macro it rises 1 cycle later.
